// File: rtl/ff_layer_sched_if.sv
// ---------------------------------------------------------------------------
// ff_layer_sched_if
//
// Bundles the control and row-address signals of the feed-forward layer
// scheduler so the scheduler and whoever drives it share one port.
//
// Handshake: start is a request level sampled only while the scheduler is
// idle. There is no ready signal; a start seen while busy/done is dropped,
// not queued. done is a one-cycle pulse that closes the pass.
// hold is a per-cycle issue suppressor: it kills the read issue of the cycle
// in which it is high and has no other effect.
//
// Signals
//   start    master->slave  request one layer pass
//   hold     master->slave  suppress issue this cycle
//   rd_en    slave->master  act/wt/bias row read this cycle
//   rd_addr  slave->master  row index being read (CW bits)
//   wr_en    slave->master  act_out/adot_out row valid to store
//   wr_addr  slave->master  output row index (CW bits)
//   busy     slave->master  pass in progress (RUN or DRAIN)
//   done     slave->master  one-cycle completion pulse
//
// CW must match the scheduler's derived CW = max(1, clog2(n*fi/z)).
// ---------------------------------------------------------------------------
interface ff_layer_sched_if #(
  parameter int CW = 2
);
  logic          start;
  logic          hold;
  logic          rd_en;
  logic [CW-1:0] rd_addr;
  logic          wr_en;
  logic [CW-1:0] wr_addr;
  logic          busy;
  logic          done;

  modport master (
    output start,
    output hold,
    input  rd_en,
    input  rd_addr,
    input  wr_en,
    input  wr_addr,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  hold,
    output rd_en,
    output rd_addr,
    output wr_en,
    output wr_addr,
    output busy,
    output done
  );
endinterface

// File: rtl/ff_layer_sched.sv
// ---------------------------------------------------------------------------
// ff_layer_sched
//
// Issue scheduler for one feed-forward layer pass. A pass reads CPC = n*fi/z
// rows of activations/weights/bias, one row per non-held cycle, and emits the
// matching output-row write strobes LAT cycles later, matching the fixed
// latency of the processor set. The processor pipeline cannot stall, so a
// held cycle simply becomes a bubble that travels down the delay line.
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   bus          ff_layer_sched_if.slave (start/hold in, rd/wr/busy/done out)
//   o_dbg_state  current FSM state (0 IDLE, 1 RUN, 2 DRAIN, 3 DONE)
//
// Parameters
//   fi   fan-in per neuron
//   z    weights/activations consumed per cycle
//   n    neurons in the layer
//   LAT  processor set latency in cycles (>= 1)
// ---------------------------------------------------------------------------
module ff_layer_sched #(
  parameter int fi  = 32,
  parameter int z   = 512,
  parameter int n   = 64,
  parameter int LAT = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  ff_layer_sched_if.slave    bus,
  output logic [1:0]         o_dbg_state
);

  localparam int CPC = (n * fi) / z;
  localparam int CW  = (CPC > 1) ? $clog2(CPC) : 1;
  localparam logic [CW-1:0] LAST = CW'(CPC - 1);

  // Reject configurations that cannot be tiled into whole rows.
  if ((z % fi) != 0 || ((n * fi) % z) != 0 || CPC < 1) begin : g_bad_cfg
    $error("ff_layer_sched: need z%%fi==0, (n*fi)%%z==0 and CPC>=1");
  end
  if (LAT < 1) begin : g_bad_lat
    $error("ff_layer_sched: LAT must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic          w_issue;
  logic          w_upstream_vld;
  logic [LAT-1:0] r_pipe_vld;
  logic [CW-1:0] r_pipe_addr [LAT];

  assign w_issue     = (r_state == S_RUN) && !bus.hold;
  assign o_dbg_state = r_state;

  // Any valid entry that has not yet reached the last stage means at least
  // one more write strobe is still on its way.
  always_comb begin
    w_upstream_vld = 1'b0;
    for (int i = 0; i < LAT - 1; i++) begin
      w_upstream_vld = w_upstream_vld | r_pipe_vld[i];
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
      S_RUN:   if (w_issue && (r_cnt == LAST)) w_state_nxt = S_DRAIN;
      // Leave DRAIN on the edge that retires the final write strobe.
      S_DRAIN: if (!w_upstream_vld) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    bus.rd_en = 1'b0;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    unique case (r_state)
      S_RUN: begin
        bus.rd_en = !bus.hold;
        bus.busy  = 1'b1;
      end
      S_DRAIN: bus.busy = 1'b1;
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

  // Issue counter: cleared on acceptance, saturates at the last row so a
  // pass can never re-issue row 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if ((r_state == S_IDLE) && bus.start) begin
      r_cnt <= '0;
    end else if (w_issue && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.rd_addr = r_cnt;

  // Valid/address delay line mirroring the processor set latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pipe_vld <= '0;
      for (int i = 0; i < LAT; i++) begin
        r_pipe_addr[i] <= '0;
      end
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_addr[i] <= r_pipe_addr[i-1];
      end
      r_pipe_vld[0]  <= w_issue;
      r_pipe_addr[0] <= r_cnt;
    end
  end

  assign bus.wr_en   = r_pipe_vld[LAT-1];
  assign bus.wr_addr = r_pipe_addr[LAT-1];

endmodule

// File: tb/tb_ff_layer_sched.sv
// ---------------------------------------------------------------------------
// tb_ff_layer_sched
//
// Drives two schedulers: A with defaults (CPC=4, LAT=3) and B with n=16,
// LAT=1 (CPC=1). Each scenario fills an issue-cycle list, expands it into
// per-cycle expected output vectors from the timing rules (write = issue +
// LAT, busy from cycle 1 to the last write, done the cycle after), and then
// replays the stimulus, popping one expected vector per cycle.
// Cycle c is the interval after edge c-1; start is sampled at edge 0.
// ---------------------------------------------------------------------------
module tb_ff_layer_sched;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset_n;
  logic [1:0] dbg_a;
  logic [1:0] dbg_b;

  always #5 clk = ~clk;

  ff_layer_sched_if #(.CW(2)) bus_a ();
  ff_layer_sched_if #(.CW(1)) bus_b ();

  ff_layer_sched u_dut_a (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus_a),
    .o_dbg_state (dbg_a)
  );

  ff_layer_sched #(.fi(32), .z(512), .n(16), .LAT(1)) u_dut_b (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus_b),
    .o_dbg_state (dbg_b)
  );

  // Packed expected vector: {rd_en, rd_addr[1:0], wr_en, wr_addr[1:0], busy, done}
  logic [W-1:0] exp_q[$];
  int  iss_q[$];
  bit  st_pat[64];
  bit  hd_pat[64];
  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc   = 0;
  bit  sel_b = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [W-1:0] pack_exp(bit re, int ra, bit we, int wa, bit b, bit d);
    return {re, ra[1:0], we, wa[1:0], b, d};
  endfunction

  // Expand iss_q into ncyc expected vectors for cycles 0..ncyc-1.
  task automatic build(input int lat, input int ncyc);
    int  last;
    bit  re, we;
    int  ra, wa;
    last = iss_q[iss_q.size()-1] + lat;
    for (int c = 0; c < ncyc; c++) begin
      re = 1'b0; we = 1'b0; ra = 0; wa = 0;
      foreach (iss_q[k]) begin
        if (iss_q[k] == c)       begin re = 1'b1; ra = k; end
        if (iss_q[k] + lat == c) begin we = 1'b1; wa = k; end
      end
      exp_q.push_back(pack_exp(re, ra, we, wa, (c >= 1) && (c <= last), c == last + 1));
    end
  endtask

  task automatic reset_check(input string tag);
    check_val({tag, "_a_rd_en"},   bus_a.rd_en,   0);
    check_val({tag, "_a_rd_addr"}, bus_a.rd_addr, 0);
    check_val({tag, "_a_wr_en"},   bus_a.wr_en,   0);
    check_val({tag, "_a_wr_addr"}, bus_a.wr_addr, 0);
    check_val({tag, "_a_busy"},    bus_a.busy,    0);
    check_val({tag, "_a_done"},    bus_a.done,    0);
    check_val({tag, "_a_state"},   dbg_a,         0);
    check_val({tag, "_b_rd_en"},   bus_b.rd_en,   0);
    check_val({tag, "_b_wr_en"},   bus_b.wr_en,   0);
    check_val({tag, "_b_busy"},    bus_b.busy,    0);
    check_val({tag, "_b_done"},    bus_b.done,    0);
    check_val({tag, "_b_state"},   dbg_b,         0);
  endtask

  // One cycle: drive inputs, optionally pulse reset, sample, compare, advance.
  task automatic run_cyc(input bit s, input bit h, input bit rp);
    logic [W-1:0] e;
    logic re, we, b, d;
    logic [1:0] ra, wa, st;
    if (sel_b) begin bus_b.start = s; bus_b.hold = h; end
    else       begin bus_a.start = s; bus_a.hold = h; end
    if (rp) reset_n = 1'b0;
    #1;
    if (sel_b) begin
      re = bus_b.rd_en; ra = {1'b0, bus_b.rd_addr}; we = bus_b.wr_en;
      wa = {1'b0, bus_b.wr_addr}; b = bus_b.busy; d = bus_b.done; st = dbg_b;
    end else begin
      re = bus_a.rd_en; ra = bus_a.rd_addr; we = bus_a.wr_en;
      wa = bus_a.wr_addr; b = bus_a.busy; d = bus_a.done; st = dbg_a;
    end
    if (exp_q.size() == 0) begin
      check_val("exp_q_underflow", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check_val("rd_en", re, e[7]);
      if (e[7]) check_val("rd_addr", ra, e[6:5]);
      check_val("wr_en", we, e[4]);
      if (e[4]) check_val("wr_addr", wa, e[3:2]);
      check_val("busy", b, e[1]);
      check_val("done", d, e[0]);
    end
    if (rp) begin
      check_val("rst_rd_addr", ra, 0);
      check_val("rst_wr_addr", wa, 0);
      check_val("rst_state",   st, 0);
      #2 reset_n = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_seq(input int ncyc, input int rst_at);
    for (int c = 0; c < ncyc; c++) begin
      run_cyc(st_pat[c], hd_pat[c], c == rst_at);
    end
    for (int c = 0; c < 64; c++) begin
      st_pat[c] = 1'b0;
      hd_pat[c] = 1'b0;
    end
  endtask

  task automatic set_iss4(input int a, input int b, input int c, input int d);
    iss_q.delete();
    iss_q.push_back(a); iss_q.push_back(b); iss_q.push_back(c); iss_q.push_back(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    reset_n     = 1'b0;
    bus_a.start = 1'b0; bus_a.hold = 1'b0;
    bus_b.start = 1'b0; bus_b.hold = 1'b0;
    for (int k = 0; k < 64; k++) begin st_pat[k] = 1'b0; hd_pat[k] = 1'b0; end

    // Reset state, with inputs active to show they are ignored in reset.
    repeat (3) @(posedge clk);
    #1;
    bus_a.start = 1'b1; bus_a.hold = 1'b1;
    #1;
    reset_check("rst");
    bus_a.hold = 1'b0;

    // Release mid-cycle with start high: first edge after release accepts.
    #1 reset_n = 1'b1;
    set_iss4(1, 2, 3, 4); build(3, 10);
    st_pat[0] = 1'b1;
    run_seq(10, -1);

    // Single hold in cycle 2.
    set_iss4(1, 3, 4, 5); build(3, 11);
    st_pat[0] = 1'b1; hd_pat[2] = 1'b1;
    run_seq(11, -1);

    // Hold through DRAIN, DONE and IDLE: timing identical to no-hold.
    set_iss4(1, 2, 3, 4); build(3, 10);
    st_pat[0] = 1'b1;
    for (int k = 5; k < 10; k++) hd_pat[k] = 1'b1;
    run_seq(10, -1);

    // start held high: back-to-back passes, period 9, start ignored when busy.
    set_iss4(1, 2, 3, 4); build(3, 9); build(3, 10);
    for (int k = 0; k < 18; k++) st_pat[k] = 1'b1;
    run_seq(19, -1);

    // Reset pulse in cycle 5: pass aborted, no late writes or done.
    set_iss4(1, 2, 3, 4); build(3, 5);
    for (int k = 0; k < 8; k++) exp_q.push_back('0);
    st_pat[0] = 1'b1;
    run_seq(13, 5);

    // A new pass after the aborted one behaves normally.
    set_iss4(1, 2, 3, 4); build(3, 10);
    st_pat[0] = 1'b1;
    run_seq(10, -1);

    // Random hold patterns across RUN and DRAIN.
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 30; k++) hd_pat[k] = ($urandom_range(0, 2) == 0);
      iss_q.delete();
      c = 1;
      for (int k = 0; k < 4; k++) begin
        while (hd_pat[c]) c++;
        iss_q.push_back(c);
        c++;
      end
      build(3, iss_q[3] + 6);
      st_pat[0] = 1'b1;
      run_seq(iss_q[3] + 6, -1);
    end

    // CPC=1, LAT=1 instance.
    sel_b = 1'b1;
    iss_q.delete(); iss_q.push_back(1); build(1, 5);
    st_pat[0] = 1'b1;
    run_seq(5, -1);

    // CPC=1: hold extends the single issuing cycle.
    iss_q.delete(); iss_q.push_back(2); build(1, 6);
    st_pat[0] = 1'b1; hd_pat[1] = 1'b1;
    run_seq(6, -1);

    check_val("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
